// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle LEGv8 main FSM and its datapath.
// master = control FSM side, slave = datapath side.
interface multicycle_control_if #(
    parameter int CNT_W = 16
);
    logic [10:0]      Opcode;
    logic             MemReady;
    logic [1:0]       ALUop;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic             Reg2Loc;
    logic             PCWrite;
    logic             PCWriteCond;
    logic             PCSource;
    logic             IRWrite;
    logic             MemRead;
    logic             MemWrite;
    logic             RegWrite;
    logic             MemToReg;
    logic [3:0]       State;
    logic             IllegalOp;
    logic             MemFault;
    logic [CNT_W-1:0] InstrCount;

    modport master (
        input  Opcode, MemReady,
        output ALUop, ALUSrcA, ALUSrcB, Reg2Loc, PCWrite, PCWriteCond, PCSource,
               IRWrite, MemRead, MemWrite, RegWrite, MemToReg, State,
               IllegalOp, MemFault, InstrCount
    );

    modport slave (
        output Opcode, MemReady,
        input  ALUop, ALUSrcA, ALUSrcB, Reg2Loc, PCWrite, PCWriteCond, PCSource,
               IRWrite, MemRead, MemWrite, RegWrite, MemToReg, State,
               IllegalOp, MemFault, InstrCount
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore main-control FSM for the multicycle LEGv8 datapath: decode, sequencing,
// memory-ready wait with timeout, and retired-instruction counting.
module multicycle_control #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic                 CLK,
    input  logic                 Reset,
    multicycle_control_if.master bus
);
    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_EXEC_R    = 4'd2;
    localparam logic [3:0] S_MEM_ADDR  = 4'd3;
    localparam logic [3:0] S_MEM_READ  = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_WB_ALU    = 4'd6;
    localparam logic [3:0] S_WB_MEM    = 4'd7;
    localparam logic [3:0] S_BR_CBZ    = 4'd8;
    localparam logic [3:0] S_BR_B      = 4'd9;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    localparam int               WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    logic [3:0]        state_q,   state_d;
    logic [10:0]       op_q,      op_d;
    logic [WAIT_W-1:0] wait_q,    wait_d;
    logic [CNT_W-1:0]  count_q,   count_d;
    logic              illegal_q, illegal_d;
    logic              fault_q,   fault_d;

    function automatic logic [3:0] decode_next(input logic [10:0] op);
        if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR)
            return S_EXEC_R;
        else if (op == OP_LDUR || op == OP_STUR)
            return S_MEM_ADDR;
        else if (op[10:3] == 8'b10110100)
            return S_BR_CBZ;
        else if (op[10:5] == 6'b000101)
            return S_BR_B;
        else
            return S_FETCH;
    endfunction

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        wait_d    = wait_q;
        count_d   = count_q;
        illegal_d = 1'b0;
        fault_d   = 1'b0;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                op_d      = bus.Opcode;
                state_d   = decode_next(bus.Opcode);
                illegal_d = (decode_next(bus.Opcode) == S_FETCH);
            end
            S_EXEC_R: state_d = S_WB_ALU;
            S_MEM_ADDR: begin
                wait_d  = '0;
                state_d = (op_q == OP_LDUR) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ, S_MEM_WRITE: begin
                // A ready on the final allowed cycle still completes normally.
                if (bus.MemReady) begin
                    if (state_q == S_MEM_READ) begin
                        state_d = S_WB_MEM;
                    end else begin
                        state_d = S_FETCH;
                        count_d = count_q + 1'b1;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_FETCH;
                    fault_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WB_ALU, S_WB_MEM, S_BR_CBZ, S_BR_B: begin
                state_d = S_FETCH;
                count_d = count_q + 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            wait_q    <= '0;
            count_q   <= '0;
            illegal_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            wait_q    <= wait_d;
            count_q   <= count_d;
            illegal_q <= illegal_d;
            fault_q   <= fault_d;
        end
    end

    always_comb begin
        bus.ALUop       = 2'b00;
        bus.ALUSrcA     = 1'b0;
        bus.ALUSrcB     = 2'b00;
        bus.Reg2Loc     = 1'b0;
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.PCSource    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.MemToReg    = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.MemRead = 1'b1;
                bus.IRWrite = 1'b1;
                bus.PCWrite = 1'b1;
                bus.ALUSrcB = 2'b01;
            end
            S_DECODE: bus.ALUSrcB = 2'b11;
            S_EXEC_R: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUop   = 2'b10;
            end
            S_MEM_ADDR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                bus.Reg2Loc = 1'b1;
            end
            S_MEM_READ: bus.MemRead = 1'b1;
            S_MEM_WRITE: begin
                bus.MemWrite = 1'b1;
                bus.Reg2Loc  = 1'b1;
            end
            S_WB_ALU: bus.RegWrite = 1'b1;
            S_WB_MEM: begin
                bus.RegWrite = 1'b1;
                bus.MemToReg = 1'b1;
            end
            S_BR_CBZ: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUop       = 2'b01;
                bus.Reg2Loc     = 1'b1;
                bus.PCWriteCond = 1'b1;
                bus.PCSource    = 1'b1;
            end
            S_BR_B: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = 1'b1;
            end
            default: ;
        endcase
        // Architectural-state writers are held off for the whole reset interval.
        if (Reset) begin
            bus.PCWrite     = 1'b0;
            bus.PCWriteCond = 1'b0;
            bus.IRWrite     = 1'b0;
            bus.MemRead     = 1'b0;
            bus.MemWrite    = 1'b0;
            bus.RegWrite    = 1'b0;
        end
    end

    assign bus.State      = state_q;
    assign bus.IllegalOp  = illegal_q;
    assign bus.MemFault   = fault_q;
    assign bus.InstrCount = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus queues per-cycle expected
// state/strobes/flags/count, a negedge monitor pops and compares them.
module tb_multicycle_control;
    localparam int CNT_W = 16;

    logic CLK = 1'b0;
    logic Reset;
    always #5 CLK = ~CLK;

    multicycle_control_if #(.CNT_W(CNT_W)) bus();

    multicycle_control #(.TIMEOUT(15), .CNT_W(CNT_W)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [1:0] alu_op;
        logic       src_a;
        logic [1:0] src_b;
        logic       reg2loc, pcw, pcwc, pcsrc, irw, mr, mw, rw, m2r;
    } ctl_t;

    typedef struct {
        int               cyc;
        logic [3:0]       st;
        ctl_t             ctl;
        logic [CNT_W-1:0] cnt;
        logic             ill;
        logic             flt;
        string            tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    ctl_t act_ctl;
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   base   = 0;

    always @(posedge CLK) cyc++;

    // Control word each state must present, written out from the state table.
    function automatic ctl_t spec_ctl(input logic [3:0] st, input bit rst);
        ctl_t c;
        c = '0;
        case (st)
            4'd0: begin c.mr = 1; c.irw = 1; c.pcw = 1; c.src_b = 2'b01; end
            4'd1: c.src_b = 2'b11;
            4'd2: begin c.src_a = 1; c.alu_op = 2'b10; end
            4'd3: begin c.src_a = 1; c.src_b = 2'b10; c.reg2loc = 1; end
            4'd4: c.mr = 1;
            4'd5: begin c.mw = 1; c.reg2loc = 1; end
            4'd6: c.rw = 1;
            4'd7: begin c.rw = 1; c.m2r = 1; end
            4'd8: begin c.src_a = 1; c.alu_op = 2'b01; c.reg2loc = 1; c.pcwc = 1; c.pcsrc = 1; end
            4'd9: begin c.pcw = 1; c.pcsrc = 1; end
            default: ;
        endcase
        if (rst) begin
            c.pcw = 0; c.pcwc = 0; c.irw = 0; c.mr = 0; c.mw = 0; c.rw = 0;
        end
        return c;
    endfunction

    task automatic ex(input string tag, input int off, input logic [3:0] st, input int cnt,
                      input bit ill, input bit flt, input bit rst);
        exp_t e;
        e.cyc = base + off;
        e.st  = st;
        e.ctl = spec_ctl(st, rst);
        e.cnt = CNT_W'(cnt);
        e.ill = ill;
        e.flt = flt;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    always @(negedge CLK) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e   = sb.pop_front();
            act_ctl = '{alu_op: bus.ALUop, src_a: bus.ALUSrcA, src_b: bus.ALUSrcB,
                        reg2loc: bus.Reg2Loc, pcw: bus.PCWrite, pcwc: bus.PCWriteCond,
                        pcsrc: bus.PCSource, irw: bus.IRWrite, mr: bus.MemRead,
                        mw: bus.MemWrite, rw: bus.RegWrite, m2r: bus.MemToReg};
            n_cmp++;
            if (mon_e.cyc != cyc || bus.State !== mon_e.st || act_ctl !== mon_e.ctl ||
                bus.InstrCount !== mon_e.cnt || bus.IllegalOp !== mon_e.ill ||
                bus.MemFault !== mon_e.flt) begin
                n_bad++;
                $display("FAIL %s cyc%0d: got st=%0d ctl=%h cnt=%0d ill=%b flt=%b, want cyc%0d st=%0d ctl=%h cnt=%0d ill=%b flt=%b",
                         mon_e.tag, cyc, bus.State, act_ctl, bus.InstrCount, bus.IllegalOp,
                         bus.MemFault, mon_e.cyc, mon_e.st, mon_e.ctl, mon_e.cnt,
                         mon_e.ill, mon_e.flt);
            end
        end
    end

    initial begin
        Reset        = 1'b1;
        bus.Opcode   = 11'd0;
        bus.MemReady = 1'b0;

        // Reset held two edges; strobes masked while high, FETCH outputs after release.
        base = 0;
        ex("reset", 1, 4'd0, 0, 0, 0, 1);
        ex("reset_rel", 2, 4'd0, 0, 0, 0, 0);
        step(2);
        Reset = 1'b0;

        // ADD: 0,1,2,6,0
        base = cyc;
        bus.Opcode = 11'b10001011000;
        ex("add", 1, 4'd1, 0, 0, 0, 0);
        ex("add", 2, 4'd2, 0, 0, 0, 0);
        ex("add", 3, 4'd6, 0, 0, 0, 0);
        ex("add", 4, 4'd0, 1, 0, 0, 0);
        step(4);

        // LDUR with three not-ready samples: four cycles in MEM_READ
        base = cyc;
        bus.Opcode = 11'b11111000010;
        ex("ldur", 1, 4'd1, 1, 0, 0, 0);
        ex("ldur", 2, 4'd3, 1, 0, 0, 0);
        for (int k = 3; k <= 6; k++) ex("ldur_wait", k, 4'd4, 1, 0, 0, 0);
        ex("ldur", 7, 4'd7, 1, 0, 0, 0);
        ex("ldur", 8, 4'd0, 2, 0, 0, 0);
        step(6);
        bus.MemReady = 1'b1;
        step(2);
        bus.MemReady = 1'b0;

        // STUR never ready: 15 cycles in MEM_WRITE, then fault pulse, no count
        base = cyc;
        bus.Opcode = 11'b11111000000;
        ex("stur_to", 1, 4'd1, 2, 0, 0, 0);
        ex("stur_to", 2, 4'd3, 2, 0, 0, 0);
        for (int k = 3; k <= 17; k++) ex("stur_to_wait", k, 4'd5, 2, 0, 0, 0);
        ex("stur_to_fault", 18, 4'd0, 2, 0, 1, 0);
        step(18);

        // STUR ready exactly on the last allowed cycle: completes, no fault
        base = cyc;
        ex("stur_edge", 1, 4'd1, 2, 0, 0, 0);
        ex("stur_edge", 2, 4'd3, 2, 0, 0, 0);
        for (int k = 3; k <= 17; k++) ex("stur_edge_wait", k, 4'd5, 2, 0, 0, 0);
        ex("stur_edge_done", 18, 4'd0, 3, 0, 0, 0);
        step(17);
        bus.MemReady = 1'b1;
        step(1);
        bus.MemReady = 1'b0;

        // CBZ then B
        base = cyc;
        bus.Opcode = 11'b10110100101;
        ex("cbz", 1, 4'd1, 3, 0, 0, 0);
        ex("cbz", 2, 4'd8, 3, 0, 0, 0);
        ex("cbz", 3, 4'd0, 4, 0, 0, 0);
        step(3);
        base = cyc;
        bus.Opcode = 11'b00010100000;
        ex("b", 1, 4'd1, 4, 0, 0, 0);
        ex("b", 2, 4'd9, 4, 0, 0, 0);
        ex("b", 3, 4'd0, 5, 0, 0, 0);
        step(3);

        // Unrecognised opcode: 0,1,0 with a one-cycle IllegalOp
        base = cyc;
        bus.Opcode = 11'b00000000000;
        ex("illegal", 1, 4'd1, 5, 0, 0, 0);
        ex("illegal_pulse", 2, 4'd0, 5, 1, 0, 0);
        step(2);

        // LDUR abandoned by reset while waiting in MEM_READ
        base = cyc;
        bus.Opcode = 11'b11111000010;
        ex("rst_mid", 1, 4'd1, 5, 0, 0, 0);
        ex("rst_mid", 2, 4'd3, 5, 0, 0, 0);
        ex("rst_mid", 3, 4'd4, 5, 0, 0, 0);
        ex("rst_mid_mask", 4, 4'd4, 5, 0, 0, 1);
        ex("rst_mid_fetch", 5, 4'd0, 0, 0, 0, 1);
        ex("rst_mid_rel", 6, 4'd0, 0, 0, 0, 0);
        step(4);
        Reset = 1'b1;
        step(2);
        Reset = 1'b0;

        // SUB after reset to confirm clean restart and counting from zero
        base = cyc;
        bus.Opcode = 11'b11001011000;
        ex("sub", 1, 4'd1, 0, 0, 0, 0);
        ex("sub", 2, 4'd2, 0, 0, 0, 0);
        ex("sub", 3, 4'd6, 0, 0, 0, 0);
        ex("sub", 4, 4'd0, 1, 0, 0, 0);
        step(6);

        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d unchecked entries, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style main control FSM for the multicycle LEGv8 datapath. It sits directly upstream of ALUControl.
- Decodes the 11-bit Opcode from the instruction register and produces ALUop (fed to ALUControl) plus all datapath strobes and mux selects.
- Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, waits on a data-memory ready handshake with timeout, and counts retired instructions.

Parameters:
- TIMEOUT, 15: maximum consecutive MemReady-low cycles tolerated in a memory state before fault.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Opcode  in  11  instruction bits [31:21] from the IR; valid from DECODE onward.
- MemReady  in  1  data memory has completed the current read or write.
- ALUop  out  2  to ALUControl. 00 = add, 01 = pass B (CBZ), 10 = R-type (decode Opcode).
- ALUSrcA  out  1  0 = PC, 1 = register A.
- ALUSrcB  out  2  00 = register B, 01 = constant 4, 10 = sign-extended D-offset, 11 = branch offset<<2.
- Reg2Loc  out  1  1 selects Rt as the second register read.
- PCWrite  out  1  unconditional PC write.
- PCWriteCond  out  1  PC write gated by ALU Zero in the datapath.
- PCSource  out  1  0 = ALU result, 1 = ALUOut.
- IRWrite  out  1  load IR.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- RegWrite  out  1  register file write.
- MemToReg  out  1  1 = write-back from MDR.
- State  out  4  current state encoding.
- IllegalOp  out  1  one-cycle pulse: unrecognised opcode.
- MemFault  out  1  one-cycle pulse: memory timeout.
- InstrCount  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (sampled on the rising edge):
  - State = FETCH (0); latched opcode, wait counter, InstrCount, IllegalOp and MemFault all 0.
  - While Reset is high, PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite and RegWrite are forced to 0.
  - Reset mid-instruction abandons the instruction with no count.
- State encodings: FETCH 0, DECODE 1, EXEC_R 2, MEM_ADDR 3, MEM_READ 4, MEM_WRITE 5, WB_ALU 6, WB_MEM 7, BR_CBZ 8, BR_B 9. Codes 10-15 go to FETCH next cycle.
- Per-state outputs (unlisted outputs are 0):
  - FETCH: MemRead, IRWrite, PCWrite; ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSource=0. Next state is DECODE.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUop=00. Latch Opcode internally; all later decisions use the latched copy.
  - DECODE next state:
    - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 -> EXEC_R.
    - LDUR 11111000010, STUR 11111000000 -> MEM_ADDR.
    - CBZ (Opcode[10:3]=10110100) -> BR_CBZ.
    - B (Opcode[10:5]=000101) -> BR_B.
    - Anything else -> FETCH, with IllegalOp=1 for the next cycle only; no count.
  - EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUop=10, Reg2Loc=0. Next state is WB_ALU.
  - WB_ALU: RegWrite=1, MemToReg=0. Next state is FETCH; count++.
  - MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUop=00, Reg2Loc=1. Next state is MEM_READ for LDUR, MEM_WRITE for STUR.
  - MEM_READ: MemRead=1. Next state is WB_MEM when MemReady=1.
  - WB_MEM: RegWrite=1, MemToReg=1. Next state is FETCH; count++.
  - MEM_WRITE: MemWrite=1, Reg2Loc=1. Next state is FETCH with count++ when MemReady=1.
  - BR_CBZ: ALUSrcA=1, ALUSrcB=00, ALUop=01, Reg2Loc=1, PCWriteCond=1, PCSource=1. Next state is FETCH; count++.
  - BR_B: PCWrite=1, PCSource=1. Next state is FETCH; count++.
- Memory wait and timeout:
  - The wait counter clears on entry to MEM_READ or MEM_WRITE.
  - Each cycle in those states with MemReady=0, the counter increments.
  - If MemReady=0 while the counter equals TIMEOUT-1: next state is FETCH, MemFault=1 for one cycle, no count.
  - MemReady=1 on that same cycle wins: normal completion, no fault.
  - Strobes stay asserted for every wait cycle.
- Latency (MemReady high on first sample): R-type 4, LDUR 5, STUR 4, CBZ 3, B 3 cycles.
- InstrCount wraps from 2^CNT_W-1 to 0 silently.
- IllegalOp and MemFault are registered and never both high.

Test Plan:
- Reset high 2 cycles then release; Opcode=10001011000 (ADD) -> State sequence 0,1,2,6,0. ALUop=10 in state 2. RegWrite=1 only in state 6. InstrCount=1.
- Opcode=11111000010 (LDUR); MemReady low 3 cycles then high -> State 0,1,3,4,4,4,4,7,0. MemRead held in every state-4 cycle. MemToReg=RegWrite=1 in state 7. InstrCount increments once.
- Opcode=11111000000 (STUR); MemReady held low -> after exactly 15 cycles in state 5, State=0 and MemFault=1 for one cycle. InstrCount unchanged.
- Opcode=10110100101 (CBZ), then 00010100000 (B) -> state 8 with ALUop=01, PCWriteCond=1, PCSource=1; then state 9 with PCWrite=1, PCSource=1. InstrCount +2.
- Opcode=00000000000 -> State 0,1,0; IllegalOp=1 for exactly one cycle; no count.
- Reset asserted during state 4 -> next edge State=0, InstrCount=0, all strobes 0 while Reset is high.
